wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 32 +++
 rtl/wb_stage.sv | 133 +++++++++++++
 tb/tb_wb_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: register-file write-select codes,
// bus widths and the writeback FSM state encoding.
package wb_stage_pkg;

    localparam int DATA_BUS     = 16;
    localparam int REG_ADDR_BUS = 3;
    localparam int REG_OP_W     = 3;

    localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

    localparam logic [REG_OP_W-1:0] REG_OP_NOP = 3'd0;
    localparam logic [REG_OP_W-1:0] REG_OP_T   = 3'd1;
    localparam logic [REG_OP_W-1:0] REG_OP_SP  = 3'd2;
    localparam logic [REG_OP_W-1:0] REG_OP_IH  = 3'd3;
    localparam logic [REG_OP_W-1:0] REG_OP_RA  = 3'd4;
    localparam logic [REG_OP_W-1:0] REG_OP_REG = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_LOAD
    } wb_state_e;

    // Encodings outside the defined set must never reach the register file.
    function automatic logic [REG_OP_W-1:0] reg_op_sanitize(input logic [REG_OP_W-1:0] op);
        case (op)
            REG_OP_T, REG_OP_SP, REG_OP_IH, REG_OP_RA, REG_OP_REG: return op;
            default:                                               return REG_OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle into the register file,
// stalling MEM while a late load is outstanding and abandoning it on timeout.
module wb_stage #(
    parameter int DATA_W       = 16,
    parameter int REG_ADDR_W   = 3,
    parameter int REG_OP_W     = 3,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_OP_W-1:0]   in_reg_op,
    input  logic [REG_ADDR_W-1:0] in_wb_addr,
    input  logic [DATA_W-1:0]     in_alu_data,
    input  logic                  in_is_load,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    input  logic                  flush,
    output logic [REG_OP_W-1:0]   reg_op,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  load_err,
    output logic [15:0]           retire_count
);
    import wb_stage_pkg::*;

    localparam logic [15:0] TIMEOUT_VAL = 16'(LOAD_TIMEOUT);

    wb_state_e             state_q, state_d;
    logic [REG_OP_W-1:0]   reg_op_q, reg_op_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  load_err_q, load_err_d;
    logic [15:0]           retire_q, retire_d;
    logic [15:0]           tcnt_q, tcnt_d;
    logic [REG_OP_W-1:0]   pend_op_q, pend_op_d;
    logic [REG_ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic                  accept;
    logic [REG_OP_W-1:0]   in_op_clean;
    logic [REG_ADDR_W-1:0] in_addr_clean;
    logic [15:0]           tcnt_inc;

    assign in_ready      = (state_q != WAIT_LOAD);
    assign accept        = in_valid & in_ready & ~flush;
    assign in_op_clean   = reg_op_sanitize(in_reg_op);
    assign in_addr_clean = (in_op_clean == REG_OP_REG) ? in_wb_addr : '0;
    assign tcnt_inc      = tcnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        reg_op_d    = REG_OP_NOP;
        wb_addr_d   = '0;
        wb_data_d   = '0;
        load_err_d  = 1'b0;
        tcnt_d      = tcnt_q;
        pend_op_d   = pend_op_q;
        pend_addr_d = pend_addr_q;
        retire_d    = retire_q;

        if (state_q == HOLD && reg_op_q != REG_OP_NOP) begin
            retire_d = retire_q + 16'd1;
        end

        case (state_q)
            IDLE, HOLD: begin
                if (!accept) begin
                    state_d = IDLE;
                end else if (in_is_load && in_op_clean != REG_OP_NOP && !mem_rvalid) begin
                    state_d     = WAIT_LOAD;
                    pend_op_d   = in_op_clean;
                    pend_addr_d = in_addr_clean;
                    tcnt_d      = '0;
                end else begin
                    state_d   = HOLD;
                    reg_op_d  = in_op_clean;
                    wb_addr_d = in_addr_clean;
                    wb_data_d = (in_is_load && mem_rvalid) ? mem_rdata : in_alu_data;
                end
            end
            WAIT_LOAD: begin
                // A flush wins over data arriving in the same cycle.
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rvalid) begin
                    state_d   = HOLD;
                    reg_op_d  = pend_op_q;
                    wb_addr_d = pend_addr_q;
                    wb_data_d = mem_rdata;
                end else if (tcnt_inc == TIMEOUT_VAL) begin
                    state_d    = IDLE;
                    load_err_d = 1'b1;
                    tcnt_d     = tcnt_inc;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_op_q    <= REG_OP_NOP;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            load_err_q  <= 1'b0;
            retire_q    <= '0;
            tcnt_q      <= '0;
            pend_op_q   <= REG_OP_NOP;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            reg_op_q    <= reg_op_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            load_err_q  <= load_err_d;
            retire_q    <= retire_d;
            tcnt_q      <= tcnt_d;
            pend_op_q   <= pend_op_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign reg_op       = reg_op_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign load_err     = load_err_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a default-timeout instance for the main flows and
// a LOAD_TIMEOUT=3 instance for the load-abandon path, sharing all inputs but in_valid.
module tb_wb_stage;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_T   = 3'd1;
    localparam logic [2:0] OP_SP  = 3'd2;
    localparam logic [2:0] OP_IH  = 3'd3;
    localparam logic [2:0] OP_RA  = 3'd4;
    localparam logic [2:0] OP_REG = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        mValid;
    logic        toValid;
    logic [2:0]  inRegOp;
    logic [2:0]  inWbAddr;
    logic [15:0] inAluData;
    logic        inIsLoad;
    logic [15:0] memRdata;
    logic        memRvalid;
    logic        flush;

    logic        mReady, toReady;
    logic [2:0]  mRegOp, toRegOp;
    logic [2:0]  mWbAddr, toWbAddr;
    logic [15:0] mWbData, toWbData;
    logic        mLoadErr, toLoadErr;
    logic [15:0] mRetire, toRetire;

    int nChecks = 0;
    int nFails  = 0;

    always #10 clk = ~clk;

    wb_stage #(.DATA_W(16), .REG_ADDR_W(3), .REG_OP_W(3), .LOAD_TIMEOUT(255)) uMain (
        .clk_50MHz(clk), .rst(rst), .in_valid(mValid), .in_ready(mReady),
        .in_reg_op(inRegOp), .in_wb_addr(inWbAddr), .in_alu_data(inAluData),
        .in_is_load(inIsLoad), .mem_rdata(memRdata), .mem_rvalid(memRvalid),
        .flush(flush), .reg_op(mRegOp), .wb_addr(mWbAddr), .wb_data(mWbData),
        .load_err(mLoadErr), .retire_count(mRetire)
    );

    wb_stage #(.DATA_W(16), .REG_ADDR_W(3), .REG_OP_W(3), .LOAD_TIMEOUT(3)) uTimeout (
        .clk_50MHz(clk), .rst(rst), .in_valid(toValid), .in_ready(toReady),
        .in_reg_op(inRegOp), .in_wb_addr(inWbAddr), .in_alu_data(inAluData),
        .in_is_load(inIsLoad), .mem_rdata(memRdata), .mem_rvalid(memRvalid),
        .flush(flush), .reg_op(toRegOp), .wb_addr(toWbAddr), .wb_data(toWbData),
        .load_err(toLoadErr), .retire_count(toRetire)
    );

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the main instance.
    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [2:0] addr,
                                 input logic [15:0] data, input logic isLoad);
        mValid    = valid;
        inRegOp   = op;
        inWbAddr  = addr;
        inAluData = data;
        inIsLoad  = isLoad;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; toValid = 1'b0; flush = 1'b0; memRvalid = 1'b0; memRdata = '0;
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("rst_regop", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("rst_data", 32'(mWbData), 32'h0);
        checkOutput("rst_addr", 32'(mWbAddr), 32'h0);
        checkOutput("rst_ready", 32'(mReady), 32'h1);
        checkOutput("rst_loaderr", 32'(mLoadErr), 32'h0);
        checkOutput("rst_retire", 32'(mRetire), 32'h0);

        $display("[TB] reset held mid-WAIT_LOAD");
        applyStimulus(1'b1, OP_REG, 3'd1, 16'h0000, 1'b1);
        tick();
        checkOutput("rstwait_ready_low", 32'(mReady), 32'h0);
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rstwait_regop", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("rstwait_data", 32'(mWbData), 32'h0);
        checkOutput("rstwait_retire", 32'(mRetire), 32'h0);
        checkOutput("rstwait_ready", 32'(mReady), 32'h1);
        memRvalid = 1'b1; memRdata = 16'hDEAD;
        tick();
        memRvalid = 1'b0;
        checkOutput("rstwait_nowrite", 32'(mRegOp), 32'(OP_NOP));

        $display("[TB] back-to-back ALU ops");
        applyStimulus(1'b1, OP_REG, 3'd3, 16'h1234, 1'b0);
        tick();
        checkOutput("b2b1_op", 32'(mRegOp), 32'(OP_REG));
        checkOutput("b2b1_addr", 32'(mWbAddr), 32'h3);
        checkOutput("b2b1_data", 32'(mWbData), 32'h1234);
        applyStimulus(1'b1, OP_SP, 3'd5, 16'hBEEF, 1'b0);
        tick();
        checkOutput("b2b2_op", 32'(mRegOp), 32'(OP_SP));
        checkOutput("b2b2_addr", 32'(mWbAddr), 32'h0);
        checkOutput("b2b2_data", 32'(mWbData), 32'hBEEF);
        checkOutput("b2b2_retire", 32'(mRetire), 32'h1);
        applyStimulus(1'b1, OP_REG, 3'd7, 16'h0001, 1'b0);
        tick();
        checkOutput("b2b3_op", 32'(mRegOp), 32'(OP_REG));
        checkOutput("b2b3_addr", 32'(mWbAddr), 32'h7);
        checkOutput("b2b3_data", 32'(mWbData), 32'h0001);
        checkOutput("b2b3_ready", 32'(mReady), 32'h1);
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        tick();
        checkOutput("b2b_idle_op", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("b2b_idle_data", 32'(mWbData), 32'h0);
        checkOutput("b2b_retire", 32'(mRetire), 32'h3);

        $display("[TB] late load, rvalid four cycles after accept");
        applyStimulus(1'b1, OP_REG, 3'd2, 16'h9999, 1'b1);
        tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        for (int w = 1; w <= 4; w++) begin
            checkOutput($sformatf("late_ready_w%0d", w), 32'(mReady), 32'h0);
            checkOutput($sformatf("late_nop_w%0d", w), 32'(mRegOp), 32'(OP_NOP));
            if (w < 4) tick();
        end
        memRvalid = 1'b1; memRdata = 16'hA5A5;
        tick();
        memRvalid = 1'b0;
        checkOutput("late_op", 32'(mRegOp), 32'(OP_REG));
        checkOutput("late_addr", 32'(mWbAddr), 32'h2);
        checkOutput("late_data", 32'(mWbData), 32'hA5A5);
        checkOutput("late_ready", 32'(mReady), 32'h1);
        tick();
        checkOutput("late_once", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("late_retire", 32'(mRetire), 32'h4);

        $display("[TB] load with same-cycle rvalid");
        applyStimulus(1'b1, OP_IH, 3'd6, 16'h1111, 1'b1);
        memRvalid = 1'b1; memRdata = 16'h00FF;
        checkOutput("fast_ready_pre", 32'(mReady), 32'h1);
        tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        memRvalid = 1'b0;
        checkOutput("fast_op", 32'(mRegOp), 32'(OP_IH));
        checkOutput("fast_addr", 32'(mWbAddr), 32'h0);
        checkOutput("fast_data", 32'(mWbData), 32'h00FF);
        checkOutput("fast_ready", 32'(mReady), 32'h1);
        tick();
        checkOutput("fast_retire", 32'(mRetire), 32'h5);

        $display("[TB] flush and rvalid together in WAIT_LOAD");
        applyStimulus(1'b1, OP_REG, 3'd4, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        checkOutput("flw_ready_low", 32'(mReady), 32'h0);
        flush = 1'b1; memRvalid = 1'b1; memRdata = 16'h7777;
        tick();
        flush = 1'b0; memRvalid = 1'b0;
        checkOutput("flw_op", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("flw_ready", 32'(mReady), 32'h1);
        tick();
        checkOutput("flw_nolate", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("flw_retire", 32'(mRetire), 32'h5);

        $display("[TB] flush while HOLD is on the outputs");
        applyStimulus(1'b1, OP_REG, 3'd6, 16'h0606, 1'b0);
        tick();
        checkOutput("flh_op", 32'(mRegOp), 32'(OP_REG));
        checkOutput("flh_addr", 32'(mWbAddr), 32'h6);
        checkOutput("flh_data", 32'(mWbData), 32'h0606);
        applyStimulus(1'b1, OP_RA, 3'd0, 16'h0BAD, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        checkOutput("flh_dropped_op", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("flh_dropped_data", 32'(mWbData), 32'h0);
        checkOutput("flh_retire", 32'(mRetire), 32'h6);

        $display("[TB] NOP load and undefined reg_op");
        applyStimulus(1'b1, OP_NOP, 3'd0, 16'h2222, 1'b1);
        tick();
        checkOutput("noplod_ready", 32'(mReady), 32'h1);
        checkOutput("noplod_op", 32'(mRegOp), 32'(OP_NOP));
        applyStimulus(1'b1, 3'd7, 3'd5, 16'h1234, 1'b0);
        tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        checkOutput("undef_op", 32'(mRegOp), 32'(OP_NOP));
        checkOutput("undef_addr", 32'(mWbAddr), 32'h0);
        tick();
        checkOutput("undef_retire", 32'(mRetire), 32'h6);

        $display("[TB] load timeout on LOAD_TIMEOUT=3 instance");
        checkOutput("to_idle_retire", 32'(toRetire), 32'h0);
        toValid = 1'b1; inRegOp = OP_REG; inWbAddr = 3'd1; inIsLoad = 1'b1;
        tick();
        toValid = 1'b0; inRegOp = OP_NOP; inWbAddr = 3'd0; inIsLoad = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            checkOutput($sformatf("to_ready_w%0d", w), 32'(toReady), 32'h0);
            checkOutput($sformatf("to_err_w%0d", w), 32'(toLoadErr), 32'h0);
            tick();
        end
        checkOutput("to_err_pulse", 32'(toLoadErr), 32'h1);
        checkOutput("to_ready_back", 32'(toReady), 32'h1);
        checkOutput("to_nowrite", 32'(toRegOp), 32'(OP_NOP));
        tick();
        checkOutput("to_err_end", 32'(toLoadErr), 32'h0);
        checkOutput("to_retire_same", 32'(toRetire), 32'h0);
        toValid = 1'b1; inRegOp = OP_T; inAluData = 16'h4242;
        tick();
        toValid = 1'b0; inRegOp = OP_NOP; inAluData = 16'h0000;
        checkOutput("to_next_op", 32'(toRegOp), 32'(OP_T));
        checkOutput("to_next_data", 32'(toWbData), 32'h4242);
        tick();
        checkOutput("to_next_retire", 32'(toRetire), 32'h1);
        checkOutput("to_main_quiet", 32'(mRetire), 32'h6);

        $display("[TB] retire counter wrap");
        applyStimulus(1'b1, OP_T, 3'd0, 16'h0042, 1'b0);
        repeat (65529) tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        tick();
        checkOutput("wrap_ffff", 32'(mRetire), 32'hFFFF);
        applyStimulus(1'b1, OP_RA, 3'd0, 16'h0001, 1'b0);
        tick();
        applyStimulus(1'b0, OP_NOP, 3'd0, 16'h0000, 1'b0);
        checkOutput("wrap_op", 32'(mRegOp), 32'(OP_RA));
        tick();
        checkOutput("wrap_zero", 32'(mRetire), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
